data_stack: RTL and testbench



---
 rtl/data_stack_pkg.sv | 18 +
 rtl/data_stack_spill_ram.sv | 27 ++
 rtl/data_stack.sv | 137 +++++++++++++
 tb/tb_data_stack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared definitions for the operand stack: op codes and default geometry.
// The decode stage imports this package, so both sides agree on the encoding.
package data_stack_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 64;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_PUSH    = 4'd1;
  localparam logic [3:0] OP_DROP    = 4'd2;
  localparam logic [3:0] OP_DUP     = 4'd3;
  localparam logic [3:0] OP_OVER    = 4'd4;
  localparam logic [3:0] OP_SWAP    = 4'd5;
  localparam logic [3:0] OP_BINOP   = 4'd6;
  localparam logic [3:0] OP_DROP2   = 4'd7;
  localparam logic [3:0] OP_REPLACE = 4'd8;

endpackage

// File: rtl/data_stack_spill_ram.sv
// Spill storage below NOS: one synchronous write port, two combinational reads, no reset.
// Callers guarantee a write and a read never hit the same address in one op.
module stack_spill_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/data_stack.sv
// Operand stack with TOS/NOS in registers and deeper entries spilled to RAM; single-cycle.
// No handshake: one op per cycle, illegal ops are dropped and latch sticky flags.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [3:0]                   op,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top_of_stack,
  output logic [WIDTH-1:0]             second_of_stack,
  output logic [$clog2(DEPTH+3)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW  = $clog2(DEPTH + 3);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp, sp_nxt;
  logic [WIDTH-1:0] tos_nxt, nos_nxt, push_val;
  logic [CW-1:0]    cnt_nxt;
  logic             ovf_set, unf_set, wr_en;
  logic [WIDTH-1:0] rd_a, rd_b, spill_a, spill_b;
  logic             has1, has2, full;

  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));
  assign full = (count == CW'(DEPTH + 2));

  // Spilled words that are not live must read as zero when they move up.
  assign spill_a = (sp != '0)       ? rd_a : '0;
  assign spill_b = (sp >= SPW'(2))  ? rd_b : '0;

  stack_spill_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK       (CLK),
    .wr_en     (wr_en),
    .wr_addr   (AW'(sp)),
    .wr_data   (second_of_stack),
    .rd_addr_a (AW'(sp - SPW'(1))),
    .rd_data_a (rd_a),
    .rd_addr_b (AW'(sp - SPW'(2))),
    .rd_data_b (rd_b)
  );

  always_comb begin
    tos_nxt  = top_of_stack;
    nos_nxt  = second_of_stack;
    cnt_nxt  = count;
    sp_nxt   = sp;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    wr_en    = 1'b0;
    push_val = din;

    case (op)
      OP_PUSH, OP_DUP, OP_OVER: begin
        if (op == OP_DUP)  push_val = top_of_stack;
        if (op == OP_OVER) push_val = second_of_stack;
        if (full) begin
          ovf_set = 1'b1;
        end else if ((op == OP_DUP && !has1) || (op == OP_OVER && !has2)) begin
          unf_set = 1'b1;
        end else begin
          tos_nxt = push_val;
          nos_nxt = top_of_stack;
          cnt_nxt = count + CW'(1);
          if (has2) begin
            wr_en  = 1'b1;
            sp_nxt = sp + SPW'(1);
          end
        end
      end
      OP_DROP, OP_BINOP: begin
        if ((op == OP_DROP && !has1) || (op == OP_BINOP && !has2)) begin
          unf_set = 1'b1;
        end else begin
          tos_nxt = (op == OP_BINOP) ? din : second_of_stack;
          nos_nxt = spill_a;
          cnt_nxt = count - CW'(1);
          if (sp != '0) sp_nxt = sp - SPW'(1);
        end
      end
      OP_SWAP: begin
        if (!has2) begin
          unf_set = 1'b1;
        end else begin
          tos_nxt = second_of_stack;
          nos_nxt = top_of_stack;
        end
      end
      OP_DROP2: begin
        if (!has2) begin
          unf_set = 1'b1;
        end else begin
          tos_nxt = spill_a;
          nos_nxt = spill_b;
          cnt_nxt = count - CW'(2);
          if (sp >= SPW'(2))   sp_nxt = sp - SPW'(2);
          else                 sp_nxt = '0;
        end
      end
      OP_REPLACE: begin
        if (!has1) unf_set = 1'b1;
        else       tos_nxt = din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      top_of_stack    <= '0;
      second_of_stack <= '0;
      count           <= '0;
      sp              <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      top_of_stack    <= tos_nxt;
      second_of_stack <= nos_nxt;
      count           <= cnt_nxt;
      sp              <= sp_nxt;
      overflow        <= overflow | ovf_set;
      underflow       <= underflow | unf_set;
    end
  end

endmodule

// File: tb/tb_data_stack.sv
// Directed and random checks of data_stack (DEPTH=4) against a queue-based stack model.
module tb_data_stack;
  import data_stack_pkg::*;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int CAP = D + 2;

  logic                       CLK = 1'b0;
  logic                       reset = 1'b1;
  logic [3:0]                 op = OP_NOP;
  logic [W-1:0]               din = '0;
  logic [W-1:0]               top_of_stack, second_of_stack;
  logic [$clog2(D+3)-1:0]     count;
  logic                       overflow, underflow;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK             (CLK),
    .reset           (reset),
    .op              (op),
    .din             (din),
    .top_of_stack    (top_of_stack),
    .second_of_stack (second_of_stack),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Abstract stack semantics: the back of the queue is the top of stack.
  task automatic model_op(input logic [3:0] o, input logic [W-1:0] d);
    int n;
    logic [W-1:0] t;
    n = mq.size();
    case (o)
      OP_PUSH:    if (n == CAP) m_ovf = 1'b1; else mq.push_back(d);
      OP_DUP:     if (n == CAP) m_ovf = 1'b1; else if (n < 1) m_unf = 1'b1; else mq.push_back(mq[n-1]);
      OP_OVER:    if (n == CAP) m_ovf = 1'b1; else if (n < 2) m_unf = 1'b1; else mq.push_back(mq[n-2]);
      OP_DROP:    if (n < 1) m_unf = 1'b1; else void'(mq.pop_back());
      OP_SWAP:    if (n < 2) m_unf = 1'b1; else begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; end
      OP_BINOP:   if (n < 2) m_unf = 1'b1; else begin void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(d); end
      OP_DROP2:   if (n < 2) m_unf = 1'b1; else begin void'(mq.pop_back()); void'(mq.pop_back()); end
      OP_REPLACE: if (n < 1) m_unf = 1'b1; else mq[n-1] = d;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".tos"}, 32'(top_of_stack),    (n >= 1) ? 32'(mq[n-1]) : 32'd0);
    check({tag, ".nos"}, 32'(second_of_stack), (n >= 2) ? 32'(mq[n-2]) : 32'd0);
    check({tag, ".cnt"}, 32'(count),           32'(n));
    check({tag, ".ovf"}, 32'(overflow),        32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow),       32'(m_unf));
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] d, input string tag);
    op  = o;
    din = d;
    @(posedge CLK);
    model_op(o, d);
    #1;
    check_all(tag);
    op = OP_NOP;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all("rst");
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check_all("por");
    @(posedge CLK); #1;
    reset = 1'b0;

    // Spill then BINOP reloads NOS from RAM
    do_op(OP_PUSH, 16'd1, "t1.p1");
    do_op(OP_PUSH, 16'd2, "t1.p2");
    do_op(OP_PUSH, 16'd3, "t1.p3");
    do_op(OP_BINOP, 16'd5, "t1.bin");
    check("t1.tos_c", 32'(top_of_stack), 32'd5);
    check("t1.nos_c", 32'(second_of_stack), 32'd1);
    check("t1.cnt_c", 32'(count), 32'd2);
    check("t1.flags", {30'd0, overflow, underflow}, 32'd0);

    do_reset();
    do_op(OP_PUSH, 16'd1, "t2.p1");
    do_op(OP_PUSH, 16'd2, "t2.p2");
    do_op(OP_OVER, 16'd0, "t2.over");
    do_op(OP_DUP,  16'd0, "t2.dup");
    check("t2.tos_c", 32'(top_of_stack), 32'd1);
    check("t2.nos_c", 32'(second_of_stack), 32'd1);
    check("t2.cnt_c", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) do_op(OP_DROP, 16'd0, "t2.drop");
    check("t2.tos_e", 32'(top_of_stack), 32'd1);
    check("t2.nos_e", 32'(second_of_stack), 32'd0);
    check("t2.cnt_e", 32'(count), 32'd1);

    do_reset();
    do_op(OP_PUSH, 16'd1, "t3.p1");
    do_op(OP_PUSH, 16'd2, "t3.p2");
    do_op(OP_PUSH, 16'd3, "t3.p3");
    do_op(OP_SWAP, 16'd0, "t3.swap");
    do_op(OP_DROP, 16'd0, "t3.drop");
    check("t3.tos_c", 32'(top_of_stack), 32'd3);
    check("t3.nos_c", 32'(second_of_stack), 32'd1);
    do_op(OP_DROP2, 16'd0, "t3.drop2");
    check("t3.cnt_e", 32'(count), 32'd0);
    check("t3.tos_e", 32'(top_of_stack), 32'd0);

    // Fill to capacity, overflow, then drain in order
    do_reset();
    for (int i = 10; i < 16; i++) do_op(OP_PUSH, 16'(i), "t4.fill");
    check("t4.cnt_full", 32'(count), 32'd6);
    check("t4.tos_full", 32'(top_of_stack), 32'd15);
    check("t4.nos_full", 32'(second_of_stack), 32'd14);
    do_op(OP_PUSH, 16'd99, "t4.ovf");
    check("t4.ovf_c", 32'(overflow), 32'd1);
    check("t4.tos_ovf", 32'(top_of_stack), 32'd15);
    for (int i = 14; i >= 9; i--) begin
      do_op(OP_DROP, 16'd0, "t4.drain");
      check("t4.drain_tos", 32'(top_of_stack), (i >= 10) ? 32'(i) : 32'd0);
    end

    do_reset();
    do_op(OP_DROP, 16'd0, "t5.drop_empty");
    check("t5.unf_c", 32'(underflow), 32'd1);
    check("t5.cnt_c", 32'(count), 32'd0);
    do_reset();
    do_op(OP_PUSH, 16'd1, "t5.p1");
    do_op(OP_SWAP, 16'd0, "t5.swap1");
    check("t5.unf_swap", 32'(underflow), 32'd1);
    check("t5.tos_swap", 32'(top_of_stack), 32'd1);

    // Asynchronous reset between edges
    do_reset();
    do_op(OP_PUSH, 16'd4, "t6.p1");
    do_op(OP_PUSH, 16'd5, "t6.p2");
    do_op(OP_PUSH, 16'd6, "t6.p3");
    #2;
    reset = 1'b1;
    #1;
    check("t6.async_tos", 32'(top_of_stack), 32'd0);
    check("t6.async_nos", 32'(second_of_stack), 32'd0);
    check("t6.async_cnt", 32'(count), 32'd0);
    mq.delete();
    reset = 1'b0;
    do_op(OP_PUSH, 16'd7, "t6.p7");
    check("t6.tos7", 32'(top_of_stack), 32'd7);
    check("t6.nos7", 32'(second_of_stack), 32'd0);
    check("t6.cnt7", 32'(count), 32'd1);

    // Random ops, reset periodically so the sticky flags stay informative
    for (int i = 0; i < 800; i++) begin
      logic [3:0] o;
      if (i % 60 == 0) do_reset();
      if ($urandom_range(0, 99) < 30) o = OP_PUSH;
      else o = 4'($urandom_range(0, 15));
      do_op(o, 16'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
